imem_boot_loader: RTL and testbench

Instruction-memory and boot block that sits directly upstream of the cardinal processor's IF stage. It drives `Instruction` from the processor's `Instr_Addr` and holds the core in reset while it runs a load sequence. A host streams a program into a 256x32 array over a byte-wide valid/ready port. The block checks an XOR checksum, pads unused words with NOP, then releases the core.

---
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_boot_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-wide load port between the boot host and the instruction-memory loader.
// The host owns start/valid/byte; the loader answers with ready.
interface imem_boot_loader_if;
  logic       Ld_Start;
  logic       Ld_Valid;
  logic [7:0] Ld_Byte;
  logic       Ld_Ready;

  modport master (
    output Ld_Start,
    output Ld_Valid,
    output Ld_Byte,
    input  Ld_Ready
  );

  modport slave (
    input  Ld_Start,
    input  Ld_Valid,
    input  Ld_Byte,
    output Ld_Ready
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction memory with boot loader. Holds the core in reset while a host
// streams a program in (header, big-endian words, XOR checksum), pads the
// rest of the array with NOP, then releases the core and serves fetches.
//
// state  | meaning
// IDLE   | after reset, core held, waiting for a load request
// HDR    | waiting for header byte H (word count N = H+1)
// DATA   | assembling words, four bytes each, MSB first
// CSUM   | waiting for checksum byte
// FILL   | writing NOP to the remaining addresses up to the top
// RUN    | core released, array visible on the fetch port
// ERR    | checksum mismatch, core held until a new load or reset
module imem_boot_loader #(
  parameter int          AW       = 8,
  parameter logic [31:0] NOP_WORD = 32'hF000_0000
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [AW-1:0] Instr_Addr,
  output logic [31:0]   Instruction,
  imem_boot_loader_if.slave ld,
  output logic          Cpu_Reset,
  output logic          Load_Done,
  output logic          Ld_Err
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_FILL,
    S_RUN,
    S_ERR
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] last_word;
  logic [1:0]    byte_cnt;
  logic [7:0]    csum;
  logic [23:0]   word_buf;
  logic [31:0]   mem [0:DEPTH-1];

  logic          accept;
  logic          mem_we;
  logic [31:0]   mem_wdata;

  assign ld.Ld_Ready = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign accept      = ld.Ld_Valid && ld.Ld_Ready;

  // Fetch path: the core only ever sees array contents while released.
  assign Instruction = (state == S_RUN) ? mem[Instr_Addr] : NOP_WORD;

  // Array write selection: completed data word or NOP padding.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = NOP_WORD;
    if (state == S_DATA && accept && byte_cnt == 2'd3) begin
      mem_we    = 1'b1;
      mem_wdata = {word_buf, ld.Ld_Byte};
    end else if (state == S_FILL) begin
      mem_we = 1'b1;
    end
  end

  // Array storage; deliberately not reset so a reset mid-load keeps finished words.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[ptr] <= mem_wdata;
    end
  end

  // Load sequencer with registered core-control outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      last_word <= '0;
      byte_cnt  <= 2'd0;
      csum      <= 8'd0;
      word_buf  <= 24'd0;
      Cpu_Reset <= 1'b1;
      Load_Done <= 1'b0;
      Ld_Err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (ld.Ld_Start) begin
            state     <= S_HDR;
            ptr       <= '0;
            byte_cnt  <= 2'd0;
            csum      <= 8'd0;
            Cpu_Reset <= 1'b1;
            Load_Done <= 1'b0;
            Ld_Err    <= 1'b0;
          end
        end

        S_HDR: begin
          if (accept) begin
            last_word <= ld.Ld_Byte[AW-1:0];
            csum      <= ld.Ld_Byte;
            byte_cnt  <= 2'd0;
            state     <= S_DATA;
          end
        end

        S_DATA: begin
          if (accept) begin
            csum     <= csum ^ ld.Ld_Byte;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[23:16] <= ld.Ld_Byte;
              2'd1: word_buf[15:8]  <= ld.Ld_Byte;
              2'd2: word_buf[7:0]   <= ld.Ld_Byte;
              default: begin
                ptr <= ptr + 1'b1;
                if (ptr == last_word) begin
                  state <= S_CSUM;
                end
              end
            endcase
          end
        end

        S_CSUM: begin
          if (accept) begin
            if (ld.Ld_Byte == csum) begin
              // A full array has nothing to pad, so release directly.
              if (last_word == {AW{1'b1}}) begin
                state     <= S_RUN;
                Cpu_Reset <= 1'b0;
                Load_Done <= 1'b1;
              end else begin
                state <= S_FILL;
              end
            end else begin
              state  <= S_ERR;
              Ld_Err <= 1'b1;
            end
          end
        end

        S_FILL: begin
          ptr <= ptr + 1'b1;
          if (ptr == {AW{1'b1}}) begin
            state     <= S_RUN;
            Cpu_Reset <= 1'b0;
            Load_Done <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for the instruction-memory boot loader.
module tb_imem_boot_loader;

  localparam logic [31:0] NOP = 32'hF000_0000;

  logic        Clock;
  logic        Reset;
  logic [7:0]  Instr_Addr;
  logic [31:0] Instruction;
  logic        Cpu_Reset;
  logic        Load_Done;
  logic        Ld_Err;

  imem_boot_loader_if ld_bus ();

  imem_boot_loader dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Instr_Addr  (Instr_Addr),
    .Instruction (Instruction),
    .ld          (ld_bus),
    .Cpu_Reset   (Cpu_Reset),
    .Load_Done   (Load_Done),
    .Ld_Err      (Ld_Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] stream [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present one byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    ld_bus.Ld_Valid = 1'b1;
    ld_bus.Ld_Byte  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (ld_bus.Ld_Ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    ld_bus.Ld_Valid = 1'b0;
    if (!ok) check_val("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_stream(input int gap_max);
    foreach (stream[i]) begin
      if (gap_max > 0) begin
        int gaps;
        gaps = $urandom_range(0, gap_max);
        ld_bus.Ld_Byte = 8'($urandom);
        repeat (gaps) tick();
      end
      send_byte(stream[i]);
    end
  endtask

  task automatic pulse_start();
    ld_bus.Ld_Start = 1'b1;
    tick();
    ld_bus.Ld_Start = 1'b0;
  endtask

  // Count edges from the checksum edge until the core is released.
  task automatic wait_release(input string tag, input int exp_edges);
    int cnt;
    cnt = 0;
    while (Cpu_Reset && cnt < 400) begin
      tick();
      cnt++;
    end
    check_val(tag, cnt, exp_edges);
  endtask

  task automatic check_word(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    Instr_Addr = addr;
    #1;
    check_val(tag, Instruction, exp);
  endtask

  task automatic one_word_stream(input logic [7:0] c);
    stream = '{8'h00, 8'h28, 8'h00, 8'h00, 8'h01, c};
  endtask

  initial begin
    Reset           = 1'b0;
    Instr_Addr      = 8'd0;
    ld_bus.Ld_Start = 1'b0;
    ld_bus.Ld_Valid = 1'b0;
    ld_bus.Ld_Byte  = 8'd0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      ld_bus.Ld_Start = 1'($urandom);
      ld_bus.Ld_Valid = 1'($urandom);
      ld_bus.Ld_Byte  = 8'($urandom);
      Instr_Addr      = 8'($urandom);
      tick();
      check_val("rst_cpu_reset", Cpu_Reset, 1);
      check_val("rst_load_done", Load_Done, 0);
      check_val("rst_ld_err", Ld_Err, 0);
      check_val("rst_ready", ld_bus.Ld_Ready, 0);
      check_val("rst_instr", Instruction, NOP);
    end
    ld_bus.Ld_Start = 1'b0;
    ld_bus.Ld_Valid = 1'b0;
    Reset = 1'b1;
    tick();
    check_val("idle_ready", ld_bus.Ld_Ready, 0);

    // One-word load, no gaps.
    pulse_start();
    check_val("hdr_ready", ld_bus.Ld_Ready, 1);
    one_word_stream(8'h29);
    send_stream(0);
    check_val("w1_cpu_reset_held", Cpu_Reset, 1);
    check_val("w1_instr_nop_fill", Instruction, NOP);
    check_val("w1_ready_fill", ld_bus.Ld_Ready, 0);
    wait_release("w1_fill_edges", 255);
    check_val("w1_load_done", Load_Done, 1);
    check_val("w1_ld_err", Ld_Err, 0);
    check_word("w1_addr0", 8'd0, 32'h2800_0001);
    check_word("w1_addr1", 8'd1, NOP);
    check_word("w1_addr255", 8'd255, NOP);

    // Reload from RUN, then a bad checksum.
    Instr_Addr = 8'd0;
    ld_bus.Ld_Start = 1'b1;
    #1;
    check_val("reload_pre_instr", Instruction, 32'h2800_0001);
    tick();
    ld_bus.Ld_Start = 1'b0;
    check_val("reload_cpu_reset", Cpu_Reset, 1);
    check_val("reload_load_done", Load_Done, 0);
    check_val("reload_instr", Instruction, NOP);
    one_word_stream(8'h2A);
    send_stream(0);
    check_val("err_ld_err", Ld_Err, 1);
    check_val("err_cpu_reset", Cpu_Reset, 1);
    check_val("err_instr", Instruction, NOP);
    repeat (5) tick();
    check_val("err_persist", Ld_Err, 1);
    check_val("err_ready", ld_bus.Ld_Ready, 0);

    // Recovery from ERR with random host gaps.
    pulse_start();
    check_val("recover_ld_err", Ld_Err, 0);
    one_word_stream(8'h29);
    send_stream(3);
    wait_release("gap_fill_edges", 255);
    check_val("gap_load_done", Load_Done, 1);
    check_val("gap_ld_err", Ld_Err, 0);
    check_word("gap_addr0", 8'd0, 32'h2800_0001);
    check_word("gap_addr1", 8'd1, NOP);

    // Full 256-word load, FILL skipped.
    stream = {};
    stream.push_back(8'hFF);
    for (int k = 0; k < 256; k++) begin
      repeat (4) stream.push_back(8'(k));
    end
    stream.push_back(8'hFF);
    pulse_start();
    send_stream(0);
    check_val("full_cpu_reset", Cpu_Reset, 0);
    check_val("full_load_done", Load_Done, 1);
    for (int k = 0; k < 256; k++) begin
      check_word("full_word", 8'(k), {4{8'(k)}});
    end

    // Async reset between the 2nd and 3rd data bytes.
    pulse_start();
    stream = '{8'h00, 8'h11, 8'h22};
    send_stream(0);
    check_val("mid_ready_before", ld_bus.Ld_Ready, 1);
    #2;
    Reset = 1'b0;
    #1;
    check_val("mid_cpu_reset", Cpu_Reset, 1);
    check_val("mid_load_done", Load_Done, 0);
    check_val("mid_ready", ld_bus.Ld_Ready, 0);
    check_val("mid_instr", Instruction, NOP);
    tick();
    Reset = 1'b1;
    // Valid in IDLE must not consume anything.
    ld_bus.Ld_Valid = 1'b1;
    ld_bus.Ld_Byte  = 8'h77;
    repeat (3) tick();
    check_val("idle_valid_ready", ld_bus.Ld_Ready, 0);
    ld_bus.Ld_Valid = 1'b0;

    // Fresh two-word load after the reset.
    pulse_start();
    stream = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01};
    send_stream(0);
    wait_release("w2_fill_edges", 254);
    check_val("w2_load_done", Load_Done, 1);
    check_word("w2_addr0", 8'd0, 32'h1234_5678);
    check_word("w2_addr1", 8'd1, 32'h9ABC_DEF0);
    check_word("w2_addr2", 8'd2, NOP);
    check_word("w2_addr255", 8'd255, NOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
